// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } arb_state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between IFU and LSU requests.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the side that did not win last; otherwise LSU wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  arb_owner_e last_grant,
  output logic       grant_ifu,
  output logic       grant_lsu
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // last_grant is still tracked by the top but has no say in fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == OWN_LSU);
`endif

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (last_grant == OWN_LSU) grant_ifu = 1'b1;
      else                       grant_lsu = 1'b1;
`else
      grant_lsu = 1'b1;
`endif
    end else begin
      grant_ifu = ifu_valid;
      grant_lsu = lsu_valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores, one transaction at a time.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking in mem_arb_pick.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W = MEM_ARB_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e          state, state_nx;
  arb_owner_e          owner, last_grant;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic                grant_ifu, grant_lsu;

  mem_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_grant (last_grant),
    .grant_ifu  (grant_ifu),
    .grant_lsu  (grant_lsu)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (ifu_req_ready || lsu_req_ready) state_nx = REQ;
      REQ:     if (mem_req_ready) state_nx = RSP;
      RSP:     if (mem_rsp_valid && mem_rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grants are gated by rst so no ready escapes while reset is held with requests pending.
  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    ifu_rdata     = '0;
    lsu_rdata     = '0;
    mem_rsp_ready = 1'b0;
    unique case (state)
      IDLE: begin
        ifu_req_ready = rst & grant_ifu;
        lsu_req_ready = rst & grant_lsu;
      end
      REQ: mem_req_valid = 1'b1;
      RSP: begin
        if (owner == OWN_IFU) begin
          ifu_rsp_valid = mem_rsp_valid;
          ifu_rdata     = mem_rdata;
          mem_rsp_ready = ifu_rsp_ready;
        end else begin
          lsu_rsp_valid = mem_rsp_valid;
          lsu_rdata     = mem_rdata;
          mem_rsp_ready = lsu_rsp_ready;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_IFU;
      last_grant <= OWN_IFU;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else if (lsu_req_ready) begin
      owner      <= OWN_LSU;
      last_grant <= OWN_LSU;
      addr_q     <= lsu_addr;
      wen_q      <= lsu_wen;
      wdata_q    <= lsu_wdata;
      wmask_q    <= lsu_wmask;
    end else if (ifu_req_ready) begin
      owner      <= OWN_IFU;
      last_grant <= OWN_IFU;
      addr_q     <= ifu_addr;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

endmodule
